// File: rtl/muldiv_pkg.sv
// Shared op codes, FSM state encoding and arithmetic helpers for mips_muldiv_unit.
package muldiv_pkg;

    localparam int ABS_MAX_W = 64;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_RSV6  = 3'b110,
        OP_RSV7  = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Two's-complement magnitude; callers sign-extend into ABS_MAX_W and truncate back.
    function automatic logic [ABS_MAX_W-1:0] abs2c(input logic [ABS_MAX_W-1:0] v);
        return v[ABS_MAX_W-1] ? (~v + ABS_MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// Request/result bundle between the control unit (master) and the multiply/divide unit (slave).
interface mips_muldiv_unit_if #(
    parameter int WIDTH = 32
);
    import muldiv_pkg::*;

    logic             start;
    op_t              op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/muldiv_iter_core.sv
// One-bit-per-cycle datapath: shift-add multiply or restoring divide over a 2*WIDTH register.
module muldiv_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               mode_div_i,
    input  logic [WIDTH-1:0]   addend_i,
    input  logic [2*WIDTH-1:0] init_i,
    output logic [2*WIDTH-1:0] acc_o
);
    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q;
    logic             div_q;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    // Multiply: upper half accumulates, lower half holds the multiplier and shifts right.
    // Divide: upper half is the partial remainder, lower half shifts in quotient bits.
    always_comb begin
        sum    = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, opnd_q};
        rem_sh = acc_q[W2-1:WIDTH-1];
        diff   = rem_sh - {1'b0, opnd_q};
        acc_d  = acc_q;
        if (div_q) begin
            if (diff[WIDTH]) begin
                acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end else begin
                acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end
        end else begin
            if (acc_q[0]) begin
                acc_d = {sum, acc_q[WIDTH-1:1]};
            end else begin
                acc_d = {1'b0, acc_q[W2-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_i) begin
            acc_q  <= init_i;
            opnd_q <= addend_i;
            div_q  <= mode_div_i;
        end else if (step_i) begin
            acc_q  <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/mips_muldiv_unit.sv
// MIPS HI/LO owner: iterative MULT/MULTU/DIV/DIVU, single-cycle MTHI/MTLO, start/busy/done handshake.
// Define MULDIV_FAST_MULT_EN to compute MULT/MULTU with one combinational multiply and skip RUN.
module mips_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    mips_muldiv_unit_if.slave bus
);
    localparam int W2    = 2 * WIDTH;
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic is_div_q, neg_res_q, neg_rem_q, div0_q;

    logic                    op_md, op_signed, op_div, accept_md, fast_mult;
    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH-1:0]        mag_a, mag_b, addend;
    logic [W2-1:0]           init_val, acc, prod;
    logic [WIDTH-1:0]        quot, rem, res_hi, res_lo;

    function automatic logic [W2-1:0] neg_w2(input logic [W2-1:0] v, input logic en);
        return en ? (~v + W2'(1)) : v;
    endfunction

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? (~v + WIDTH'(1)) : v;
    endfunction

    always_comb begin
        op_div    = (bus.op == OP_DIV) || (bus.op == OP_DIVU);
        op_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);
        op_md     = op_div || (bus.op == OP_MULT) || (bus.op == OP_MULTU);
    end

    assign accept_md = (state_q == ST_IDLE) && bus.start && op_md;
    assign a_s       = bus.src_a;
    assign b_s       = bus.src_b;
    assign mag_a     = op_signed ? WIDTH'(abs2c(ABS_MAX_W'(a_s))) : bus.src_a;
    assign mag_b     = op_signed ? WIDTH'(abs2c(ABS_MAX_W'(b_s))) : bus.src_b;
    assign addend    = op_div ? mag_b : mag_a;

`ifdef MULDIV_FAST_MULT_EN
    assign fast_mult = !op_div;
    assign init_val  = op_div ? {{WIDTH{1'b0}}, mag_a} : (W2'(mag_a) * W2'(mag_b));
`else
    assign fast_mult = 1'b0;
    assign init_val  = {{WIDTH{1'b0}}, op_div ? mag_a : mag_b};
`endif

    muldiv_iter_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk        (clk),
        .load_i     (accept_md),
        .step_i     (state_q == ST_RUN),
        .mode_div_i (op_div),
        .addend_i   (addend),
        .init_i     (init_val),
        .acc_o      (acc)
    );

    // Sign correction applied in FINISH; a zero divisor forces LO to all ones.
    always_comb begin
        prod = neg_w2(acc, neg_res_q);
        quot = neg_w(acc[WIDTH-1:0], neg_res_q);
        rem  = neg_w(acc[W2-1:WIDTH], neg_rem_q);
        if (is_div_q) begin
            res_hi = rem;
            res_lo = div0_q ? {WIDTH{1'b1}} : quot;
        end else begin
            res_hi = prod[W2-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (op_md) begin
                        state_d = fast_mult ? ST_FINISH : ST_RUN;
                        cnt_d   = '0;
                    end else if (bus.op == OP_MTHI) begin
                        hi_d   = bus.src_a;
                        done_d = 1'b1;
                    end else if (bus.op == OP_MTLO) begin
                        lo_d   = bus.src_a;
                        done_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                hi_d    = res_hi;
                lo_d    = res_lo;
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Operation attributes are only consumed after an accept, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept_md) begin
            is_div_q  <= op_div;
            neg_res_q <= op_signed && (a_s[WIDTH-1] ^ b_s[WIDTH-1]);
            neg_rem_q <= op_signed && a_s[WIDTH-1];
            div0_q    <= (bus.src_b == '0);
        end
    end

    assign bus.busy = (state_q != ST_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: latency, busy window, HI/LO results and handshake corners.
module tb_mips_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           lat;
    } exp_t;

    logic clk;
    logic rst_n;
    int   nerr;
    int   nchk;
    logic [W-1:0] hi_m;
    logic [W-1:0] lo_m;
    exp_t sb[$];

    mips_muldiv_unit_if #(.WIDTH(W)) bus ();

    mips_muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int lat_of(input op_t op);
`ifdef MULDIV_FAST_MULT_EN
        return (op == OP_MULT || op == OP_MULTU) ? 2 : W + 2;
`else
        return W + 2;
`endif
    endfunction

    function automatic void model(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] h, output logic [W-1:0] l);
        longint sa, sbv;
        logic [63:0] p;
        sa  = $signed(a);
        sbv = $signed(b);
        p   = '0;
        h   = '0;
        l   = '0;
        case (op)
            OP_MULT:  begin p = 64'(sa * sbv); h = p[63:32]; l = p[31:0]; end
            OP_MULTU: begin p = {32'b0, a} * {32'b0, b}; h = p[63:32]; l = p[31:0]; end
            OP_DIV: begin
                if (b == 0) begin h = a; l = '1; end
                else begin l = W'(sa / sbv); h = W'(sa % sbv); end
            end
            OP_DIVU: begin
                if (b == 0) begin h = a; l = '1; end
                else begin l = a / b; h = a % b; end
            end
            default: ;
        endcase
    endfunction

    // Issues one mult/div, optionally in the current (done) cycle, and checks the whole transaction.
    task automatic run_op(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eh, input logic [W-1:0] el,
                          input bit b2b, input int inj, input string nm);
        exp_t e;
        int cyc, bcnt;
        bit stale_bad;
        if (!b2b) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        e.hi = eh; e.lo = el; e.lat = lat_of(op);
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.src_a = $urandom;
        bus.src_b = $urandom;
        cyc = 1; bcnt = 0; stale_bad = 0;
        while (!bus.done && cyc < 100) begin
            if (bus.busy) bcnt++;
            if (bus.hi !== hi_m || bus.lo !== lo_m) stale_bad = 1;
            if (inj != 0 && cyc == inj) begin
                bus.start = 1'b1;
                bus.op    = OP_MTHI;
                bus.src_a = 32'h0000_1234;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        e = sb.pop_front();
        nchk++;
        if (bus.done !== 1'b1) begin
            nerr++; $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", nm, bus.done, cyc);
        end
        nchk++;
        if (cyc !== e.lat) begin
            nerr++; $display("FAIL %s_latency: got %0d cycles, required %0d", nm, cyc, e.lat);
        end
        nchk++;
        if (bcnt !== e.lat - 1) begin
            nerr++; $display("FAIL %s_busy_cycles: got %0d, required %0d", nm, bcnt, e.lat - 1);
        end
        nchk++;
        if (bus.busy !== 1'b0) begin
            nerr++; $display("FAIL %s_busy_at_done: got %b, required 0", nm, bus.busy);
        end
        nchk++;
        if (stale_bad) begin
            nerr++; $display("FAIL %s_hilo_held: HI/LO changed while busy", nm);
        end
        nchk++;
        if (bus.hi !== e.hi) begin
            nerr++; $display("FAIL %s_hi: got %h, required %h", nm, bus.hi, e.hi);
        end
        nchk++;
        if (bus.lo !== e.lo) begin
            nerr++; $display("FAIL %s_lo: got %h, required %h", nm, bus.lo, e.lo);
        end
        hi_m = e.hi;
        lo_m = e.lo;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        nchk++;
        if ({bus.hi, bus.lo, bus.busy, bus.done} !== {{(2*W){1'b0}}, 2'b00}) begin
            nerr++; $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b, required all 0",
                             bus.hi, bus.lo, bus.busy, bus.done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        nchk++;
        if ({bus.hi, bus.lo, bus.busy, bus.done} !== {{(2*W){1'b0}}, 2'b00}) begin
            nerr++; $display("FAIL reset_release: hi=%h lo=%h busy=%b done=%b, required all 0",
                             bus.hi, bus.lo, bus.busy, bus.done);
        end
        hi_m = '0;
        lo_m = '0;
    endtask

    task automatic test_multu();
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0, "multu_max");
        @(negedge clk);
        nchk++;
        if (bus.done !== 1'b0) begin
            nerr++; $display("FAIL done_pulse_width: done=%b one cycle later, required 0", bus.done);
        end
    endtask

    task automatic test_mult();
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 0, 0, "mult_neg3x5");
        run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, 0, "mult_minxmin");
    endtask

    task automatic test_div();
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, "div_neg7by2");
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 0, "div_overflow");
        run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 0, 0, "div_7byneg2");
    endtask

    task automatic test_div_zero();
        run_op(OP_DIVU, 32'h0000_0064, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 0, 0, "divu_by0");
        run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0, 0, "div_neg_by0");
    endtask

    task automatic test_busy_ignore();
        run_op(OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 0, 5, "div_ignore_mthi");
    endtask

    task automatic test_mthi_mtlo();
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MTHI; bus.src_a = 32'h0000_1234;
        e.hi = 32'h0000_1234; e.lo = lo_m; e.lat = 1;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        e = sb.pop_front();
        nchk++;
        if ({bus.hi, bus.lo, bus.done, bus.busy} !== {e.hi, e.lo, 2'b10}) begin
            nerr++; $display("FAIL mthi: hi=%h lo=%h done=%b busy=%b, required hi=%h lo=%h done=1 busy=0",
                             bus.hi, bus.lo, bus.done, bus.busy, e.hi, e.lo);
        end
        hi_m = e.hi;
        @(negedge clk);
        nchk++;
        if ({bus.done, bus.busy} !== 2'b00 || bus.hi !== hi_m) begin
            nerr++; $display("FAIL mthi_after: done=%b busy=%b hi=%h, required 0 0 %h",
                             bus.done, bus.busy, bus.hi, hi_m);
        end
        bus.start = 1'b1; bus.op = OP_MTLO; bus.src_a = 32'hCAFE_F00D;
        e.hi = hi_m; e.lo = 32'hCAFE_F00D; e.lat = 1;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        e = sb.pop_front();
        nchk++;
        if ({bus.hi, bus.lo, bus.done, bus.busy} !== {e.hi, e.lo, 2'b10}) begin
            nerr++; $display("FAIL mtlo: hi=%h lo=%h done=%b busy=%b, required hi=%h lo=%h done=1 busy=0",
                             bus.hi, bus.lo, bus.done, bus.busy, e.hi, e.lo);
        end
        lo_m = e.lo;
    endtask

    task automatic test_reserved();
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_RSV6; bus.src_a = 32'hFFFF_0000; bus.src_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        nchk++;
        if ({bus.done, bus.busy} !== 2'b00 || bus.hi !== hi_m || bus.lo !== lo_m) begin
            nerr++; $display("FAIL reserved_op: done=%b busy=%b hi=%h lo=%h, required 0 0 %h %h",
                             bus.done, bus.busy, bus.hi, bus.lo, hi_m, lo_m);
        end
        @(negedge clk);
        nchk++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            nerr++; $display("FAIL reserved_op_late: done=%b busy=%b, required 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_back_to_back();
        run_op(OP_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 0, 0, "b2b_first");
        run_op(OP_MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1, 0, "b2b_second");
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, h, l;
        op_t op;
        for (int i = 0; i < 8; i++) begin
            op = op_t'(3'($urandom_range(0, 3)));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : W'($urandom >> $urandom_range(0, 28));
            model(op, a, b, h, l);
            run_op(op, a, b, h, l, i[0], 0, "random");
        end
    endtask

    task automatic test_midop_reset();
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIV; bus.src_a = 32'hFFFF_FFF9; bus.src_b = 32'd2;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        nchk++;
        if ({bus.hi, bus.lo, bus.busy, bus.done} !== {{(2*W){1'b0}}, 2'b00}) begin
            nerr++; $display("FAIL midop_reset: hi=%h lo=%h busy=%b done=%b, required all 0",
                             bus.hi, bus.lo, bus.busy, bus.done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        hi_m = '0;
        lo_m = '0;
        run_op(OP_MULTU, 32'd2, 32'd3, 32'd0, 32'd6, 0, 0, "after_reset_multu");
    endtask

    initial begin
        nerr = 0;
        nchk = 0;
        hi_m = '0;
        lo_m = '0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.op    = OP_MULT;
        bus.src_a = '0;
        bus.src_b = '0;
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_zero();
        test_busy_ignore();
        test_mthi_mtlo();
        test_reserved();
        test_back_to_back();
        test_random();
        test_midop_reset();
        nchk++;
        if (sb.size() !== 0) begin
            nerr++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
